// File: rtl/mem_responder_if.sv
// Core-side memory port plus console sink and board outputs of the memory responder.
interface mem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [7:0]  gpio;
    logic        bad_addr;

    modport master (
        output mem_addr, mem_write, mem_wdata, tx_ready,
        input  mem_rdata, tx_valid, tx_data, gpio, bad_addr
    );

    modport slave (
        input  mem_addr, mem_write, mem_wdata, tx_ready,
        output mem_rdata, tx_valid, tx_data, gpio, bad_addr
    );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder: synchronous RAM plus an MMIO window holding a console FIFO,
// a cycle-counter snapshot and a GPIO register. Read data returns one cycle after the address.
module mem_responder #(
    parameter int unsigned RAM_BYTES  = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mem_responder_if.slave bus
);
    localparam int AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic sel_ram, sel_con, sel_stat, sel_gpio, mapped, wr;
    logic sel_cyc0, sel_cyc1, sel_cyc2, sel_cyc3;

    logic [7:0]    ram_q [RAM_BYTES];
    logic [7:0]    ram_rd_q;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cyc_q, cyc_d, snap_q, snap_d;
    logic [7:0]    gpio_q, gpio_d;
    logic          bad_q, bad_d;
    logic [7:0]    reg_rd_q, reg_rd_d;
    logic          src_ram_q, src_ram_d;
    logic          empty, full, pop, push_req, push;

    // Address decode; writes presented while in reset are masked here once for all targets.
    always_comb begin
        sel_ram  = bus.mem_addr < 32'(RAM_BYTES);
        sel_con  = bus.mem_addr == MMIO_BASE;
        sel_stat = bus.mem_addr == MMIO_BASE + 32'd1;
        sel_cyc0 = bus.mem_addr == MMIO_BASE + 32'd4;
        sel_cyc1 = bus.mem_addr == MMIO_BASE + 32'd5;
        sel_cyc2 = bus.mem_addr == MMIO_BASE + 32'd6;
        sel_cyc3 = bus.mem_addr == MMIO_BASE + 32'd7;
        sel_gpio = bus.mem_addr == MMIO_BASE + 32'd8;
        mapped   = sel_ram | sel_con | sel_stat | sel_cyc0 | sel_cyc1 | sel_cyc2
                 | sel_cyc3 | sel_gpio;
        wr       = bus.mem_write & ~i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (wr && sel_ram) begin
            ram_q[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
        end
        ram_rd_q <= ram_q[bus.mem_addr[AW-1:0]];
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == FULL_CNT;
        pop      = !empty && bus.tx_ready;
        push_req = wr && sel_con;
        push     = push_req && (!full || pop);
        rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q;
        if (wr && sel_stat) begin
            ovf_d = 1'b0;
        end else if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wptr_q] <= bus.mem_wdata;
        end
    end

    always_comb begin
        cyc_d     = cyc_q + 32'd1;
        snap_d    = (wr && sel_cyc0) ? cyc_q : snap_q;
        gpio_d    = (wr && sel_gpio) ? bus.mem_wdata : gpio_q;
        bad_d     = wr && !mapped;
        src_ram_d = sel_ram;
        reg_rd_d  = 8'h00;
        if (sel_stat) begin
            reg_rd_d = {4'(cnt_q), 1'b0, ovf_q, full, empty};
        end else if (sel_cyc0) begin
            reg_rd_d = snap_q[31:24];
        end else if (sel_cyc1) begin
            reg_rd_d = snap_q[23:16];
        end else if (sel_cyc2) begin
            reg_rd_d = snap_q[15:8];
        end else if (sel_cyc3) begin
            reg_rd_d = snap_q[7:0];
        end else if (sel_gpio) begin
            reg_rd_d = gpio_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            cyc_q     <= 32'd0;
            snap_q    <= 32'd0;
            gpio_q    <= 8'h00;
            bad_q     <= 1'b0;
            reg_rd_q  <= 8'h00;
            src_ram_q <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            gpio_q    <= gpio_d;
            bad_q     <= bad_d;
            reg_rd_q  <= reg_rd_d;
            src_ram_q <= src_ram_d;
        end
    end

    // Head byte is forced to zero when empty so the reset value is defined.
    always_comb begin
        bus.mem_rdata = src_ram_q ? ram_rd_q : reg_rd_q;
        bus.tx_valid  = !empty;
        bus.tx_data   = empty ? 8'h00 : fifo_q[rptr_q];
        bus.gpio      = gpio_q;
        bus.bad_addr  = bad_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table vectors, directed corner sequences and
// randomized traffic compared against a transaction-level model.
module tb_mem_responder;
    localparam int          RAM_BYTES = 4096;
    localparam logic [31:0] BASE      = 32'hFFFF_0000;
    localparam int          DEPTH     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.RAM_BYTES(RAM_BYTES), .MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  m_ram [RAM_BYTES];
    bit          m_ok  [RAM_BYTES];
    logic [7:0]  m_q[$];
    bit          m_ovf;
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_gpio, m_rd;
    bit          m_bad, m_rd_known;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_gpio;
        logic        exp_bad;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'(m_q.size()), 1'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    // Returns {known, byte} for a read of address a with the current model state.
    function automatic logic [8:0] m_read(input logic [31:0] a);
        if (a < 32'(RAM_BYTES)) return {m_ok[a[11:0]], m_ram[a[11:0]]};
        if (a == BASE + 32'd1) return {1'b1, m_status()};
        if (a == BASE + 32'd4) return {1'b1, m_snap[31:24]};
        if (a == BASE + 32'd5) return {1'b1, m_snap[23:16]};
        if (a == BASE + 32'd6) return {1'b1, m_snap[15:8]};
        if (a == BASE + 32'd7) return {1'b1, m_snap[7:0]};
        if (a == BASE + 32'd8) return {1'b1, m_gpio};
        return 9'h100;
    endfunction

    function automatic bit m_mapped(input logic [31:0] a);
        return a < 32'(RAM_BYTES) || a == BASE || a == BASE + 32'd1
            || (a >= BASE + 32'd4 && a <= BASE + 32'd8);
    endfunction

    // One bus cycle: drive at negedge, advance the model at posedge, compare just after.
    task automatic step(input logic [31:0] a, input logic we, input logic [7:0] d,
                        input logic rdy, input logic r);
        logic [8:0] rd;
        @(negedge clk);
        bus.mem_addr = a; bus.mem_write = we; bus.mem_wdata = d; bus.tx_ready = rdy; rst = r;
        rd = m_read(a);
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_ovf = 0; m_cnt = 0; m_snap = 0; m_gpio = 0; m_bad = 0;
            m_rd = 8'h00; m_rd_known = 1;
        end else begin
            m_rd = rd[7:0]; m_rd_known = rd[8];
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            m_bad = we && !m_mapped(a);
            if (we) begin
                if (a < 32'(RAM_BYTES)) begin
                    m_ram[a[11:0]] = d; m_ok[a[11:0]] = 1;
                end
                if (a == BASE) begin
                    if (m_q.size() < DEPTH) m_q.push_back(d);
                    else m_ovf = 1;
                end
                if (a == BASE + 32'd1) m_ovf = 0;
                if (a == BASE + 32'd4) m_snap = m_cnt;
                if (a == BASE + 32'd8) m_gpio = d;
            end
            m_cnt = m_cnt + 32'd1;
        end
        #1;
        if (m_rd_known) chk("rdata", 32'(bus.mem_rdata), 32'(m_rd));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
        chk("gpio", 32'(bus.gpio), 32'(m_gpio));
        chk("bad_addr", 32'(bus.bad_addr), 32'(m_bad));
    endtask

    task automatic idle(input logic rdy);
        step(32'h40, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] a;
        logic [7:0]  last;
        int          pops;

        bus.mem_addr = 0; bus.mem_write = 0; bus.mem_wdata = 0; bus.tx_ready = 0;
        for (int i = 0; i < RAM_BYTES; i++) m_ok[i] = 0;

        // Reset state
        step(32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(32'h0, 1'b1, 8'hEE, 1'b1, 1'b1);
        chk("rst_rdata", 32'(bus.mem_rdata), 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_gpio", 32'(bus.gpio), 32'h0);
        chk("rst_bad", 32'(bus.bad_addr), 32'h0);
        step(BASE + 32'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_status", 32'(bus.mem_rdata), 32'h01);

        // RAM round trip, GPIO and unmapped write
        vecs[0] = '{32'h10,         1'b1, 8'hA5, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{32'h10,         1'b0, 8'h00, 8'hA5, 8'h00, 1'b0};
        vecs[2] = '{32'h10,         1'b1, 8'h5A, 8'hA5, 8'h00, 1'b0};
        vecs[3] = '{32'h10,         1'b0, 8'h00, 8'h5A, 8'h00, 1'b0};
        vecs[4] = '{BASE + 32'd8,   1'b1, 8'h3C, 8'h00, 8'h3C, 1'b0};
        vecs[5] = '{BASE + 32'd8,   1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0};
        vecs[6] = '{BASE + 32'h20,  1'b1, 8'hFF, 8'h00, 8'h3C, 1'b1};
        vecs[7] = '{BASE + 32'd8,   1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].addr, vecs[i].we, vecs[i].data, 1'b0, 1'b0);
            if (i != 0) chk("vec_rdata", 32'(bus.mem_rdata), 32'(vecs[i].exp_rd));
            chk("vec_gpio", 32'(bus.gpio), 32'(vecs[i].exp_gpio));
            chk("vec_bad", 32'(bus.bad_addr), 32'(vecs[i].exp_bad));
        end

        // Cycle snapshot at counter value 100
        step(32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
        while (m_cnt != 32'd100) idle(1'b0);
        step(BASE + 32'd4, 1'b1, 8'h00, 1'b0, 1'b0);
        step(BASE + 32'd4, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("snap_b0", 32'(bus.mem_rdata), 32'h00);
        step(BASE + 32'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("snap_b1", 32'(bus.mem_rdata), 32'h00);
        step(BASE + 32'd6, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("snap_b2", 32'(bus.mem_rdata), 32'h00);
        for (int i = 0; i < 20; i++) idle(1'b0);
        step(BASE + 32'd7, 1'b1, 8'h99, 1'b0, 1'b0);
        step(BASE + 32'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("snap_b3", 32'(bus.mem_rdata), 32'h64);

        // Console: overflow, drain, OVF clear
        for (int k = 1; k <= 9; k++) step(BASE, 1'b1, 8'(k), 1'b0, 1'b0);
        step(BASE + 32'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fifo_status_full", 32'(bus.mem_rdata), 32'h86);
        chk("fifo_head", 32'(bus.tx_data), 32'h01);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_order", 32'(bus.tx_data), 32'(k));
            idle(1'b1);
        end
        chk("drained_valid", 32'(bus.tx_valid), 32'h0);
        step(BASE + 32'd1, 1'b1, 8'h00, 1'b0, 1'b0);
        step(BASE + 32'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_cleared", 32'(bus.mem_rdata), 32'h01);

        // Push and pop together while full
        for (int k = 0; k < 8; k++) step(BASE, 1'b1, 8'h11 + 8'(k), 1'b0, 1'b0);
        step(BASE, 1'b1, 8'h77, 1'b1, 1'b0);
        step(BASE + 32'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_pushpop_status", 32'(bus.mem_rdata), 32'h82);
        last = 8'h00; pops = 0;
        for (int k = 0; k < 12 && bus.tx_valid; k++) begin
            last = bus.tx_data; pops++;
            idle(1'b1);
        end
        chk("full_pushpop_last", 32'(last), 32'h77);
        chk("full_pushpop_pops", 32'(pops), 32'd8);

        // Counter wrap
        force dut.cyc_q = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_q;
        m_cnt = 32'hFFFF_FFFE;
        step(BASE + 32'd4, 1'b1, 8'h00, 1'b0, 1'b0);
        step(BASE + 32'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_pre_b3", 32'(bus.mem_rdata), 32'hFE);
        step(BASE + 32'd4, 1'b1, 8'h00, 1'b0, 1'b0);
        step(BASE + 32'd4, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_b0", 32'(bus.mem_rdata), 32'h00);
        step(BASE + 32'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_b3", 32'(bus.mem_rdata), 32'h00);

        // Reset mid-drain
        for (int k = 0; k < 3; k++) step(BASE, 1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0);
        step(BASE + 32'd8, 1'b1, 8'h55, 1'b0, 1'b0);
        idle(1'b1);
        step(BASE + 32'd8, 1'b1, 8'h99, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
        chk("mid_rst_gpio", 32'(bus.gpio), 32'h0);
        step(BASE + 32'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_rst_status", 32'(bus.mem_rdata), 32'h01);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 32'($urandom_range(0, 31));
                2, 3:    a = BASE + 32'($urandom_range(0, 9));
                4:       a = ($urandom_range(0, 1) != 0) ? BASE + 32'h20 : $urandom;
                default: a = 32'($urandom_range(RAM_BYTES - 4, RAM_BYTES + 3));
            endcase
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
